// File: rtl/pulse_pkg.sv
// ---------------------------------------------------------------------------
// pulse_pkg
//   Shared definitions for the pulse burst counter slice.
//   - FSM state encoding (2 bits; 2'b11 is unused and recovers to IDLE)
//   - BCD digit width
//   - to_bcd(): converts a small binary constant (0..99) to two BCD digits
// ---------------------------------------------------------------------------
package pulse_pkg;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_WINDOW = 2'b01;
   localparam logic [1:0] ST_REPORT = 2'b10;

   localparam int BCD_W = 4;

   function automatic logic [2*BCD_W-1:0] to_bcd(input int v);
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] ones;
      tens   = BCD_W'(v / 10);
      ones   = BCD_W'(v % 10);
      to_bcd = {tens, ones};
   endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// ---------------------------------------------------------------------------
// bcd_counter_2d
//   Two-digit BCD counter that saturates at CNT_MAX.
//   Ports:
//     clk       system clock, rising edge
//     reset     asynchronous active-low reset, clears value
//     load      load load_val (has priority over inc)
//     load_val  BCD value to load, [7:4] tens, [3:0] ones
//     inc       increment by one in BCD unless already at CNT_MAX
//     value     current count, BCD
//     at_max    value equals CNT_MAX
// ---------------------------------------------------------------------------
module bcd_counter_2d
   import pulse_pkg::*;
#(
   parameter int CNT_MAX = 99
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [2*BCD_W-1:0]   load_val,
   input  logic                 inc,
   output logic [2*BCD_W-1:0]   value,
   output logic                 at_max
);

   localparam logic [2*BCD_W-1:0] MAX_BCD = to_bcd(CNT_MAX);

   logic [BCD_W-1:0] tens;
   logic [BCD_W-1:0] ones;

   assign tens   = value[2*BCD_W-1:BCD_W];
   assign ones   = value[BCD_W-1:0];
   assign at_max = (value == MAX_BCD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (inc && !at_max) begin
         // ones wrap 9->0 and carry into tens
         if (ones == BCD_W'(9)) begin
            value <= {tens + BCD_W'(1), BCD_W'(0)};
         end else begin
            value <= {tens, ones + BCD_W'(1)};
         end
      end
   end

endmodule

// File: rtl/pulse_burst_counter.sv
// ---------------------------------------------------------------------------
// pulse_burst_counter
//   Counts rising edges of p_in while the window input l_in is high and
//   reports the BCD count (with overflow flag) when the window closes.
//   Ports:
//     clk       system clock, rising edge
//     reset     asynchronous active-low reset
//     p_in      pulse input, one event per rising edge
//     l_in      window input, window open while high
//     clr       synchronous clear, overrides everything else
//     live_bcd  running count of the current window, BCD
//     last_bcd  count captured at the most recent window close, BCD
//     last_ovf  overflow flag captured with last_bcd
//     ovf       overflow of the current window, sticky until restart
//     done      one-cycle strobe while in REPORT
//     busy      high while in WINDOW
//   CNT_MAX (1..99) is the saturation value of the count.
// ---------------------------------------------------------------------------
module pulse_burst_counter
   import pulse_pkg::*;
#(
   parameter int CNT_MAX = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       p_in,
   input  logic       l_in,
   input  logic       clr,
   output logic [7:0] live_bcd,
   output logic [7:0] last_bcd,
   output logic       last_ovf,
   output logic       ovf,
   output logic       done,
   output logic       busy
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       p_q;
   logic       p_rise;
   logic       at_max;
   logic       cnt_load;
   logic [7:0] cnt_load_val;
   logic       cnt_inc;
   logic       win_start;
   logic       win_close;
   logic       sat_hit;

   // Both inputs are in this clock domain, so a single register suffices.
   assign p_rise = p_in & ~p_q;

   assign win_start = !clr && l_in && ((state == ST_IDLE) || (state == ST_REPORT));
   assign win_close = !clr && !l_in && (state == ST_WINDOW);
   assign sat_hit   = !clr && l_in && (state == ST_WINDOW) && p_rise && at_max;

   always_comb begin
      state_nxt    = ST_IDLE;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_inc      = 1'b0;
      if (clr) begin
         state_nxt = ST_IDLE;
         cnt_load  = 1'b1;
      end else begin
         case (state)
            ST_IDLE, ST_REPORT: begin
               if (l_in) begin
                  // an edge coincident with the window opening counts as 1
                  state_nxt    = ST_WINDOW;
                  cnt_load     = 1'b1;
                  cnt_load_val = {7'd0, p_rise};
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_WINDOW: begin
               if (l_in) begin
                  state_nxt = ST_WINDOW;
                  cnt_inc   = p_rise;
               end else begin
                  // closing cycle: the edge (if any) is not counted
                  state_nxt = ST_REPORT;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         p_q      <= 1'b0;
         ovf      <= 1'b0;
         last_bcd <= '0;
         last_ovf <= 1'b0;
      end else begin
         state <= state_nxt;
         p_q   <= clr ? 1'b0 : p_in;
         if (clr) begin
            ovf      <= 1'b0;
            last_bcd <= '0;
            last_ovf <= 1'b0;
         end else begin
            if (win_start) begin
               ovf <= 1'b0;
            end else if (sat_hit) begin
               ovf <= 1'b1;
            end
            if (win_close) begin
               last_bcd <= live_bcd;
               last_ovf <= ovf;
            end
         end
      end
   end

   bcd_counter_2d #(
      .CNT_MAX (CNT_MAX)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .inc      (cnt_inc),
      .value    (live_bcd),
      .at_max   (at_max)
   );

   assign done = (state == ST_REPORT);
   assign busy = (state == ST_WINDOW);

endmodule

// File: tb/tb_pulse_burst_counter.sv
// ---------------------------------------------------------------------------
// tb_pulse_burst_counter
//   Directed bench for pulse_burst_counter. Window closes push the expected
//   {last_bcd, last_ovf} into exp_q; a monitor pops and compares on done.
//   Inputs are driven on the falling edge, outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_pulse_burst_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       p_in = 1'b0;
   logic       l_in = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] live_bcd;
   logic [7:0] last_bcd;
   logic       last_ovf;
   logic       ovf;
   logic       done;
   logic       busy;

   logic [8:0] exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   pulse_burst_counter #(.CNT_MAX(99)) dut (
      .clk      (clk),
      .reset    (reset),
      .p_in     (p_in),
      .l_in     (l_in),
      .clr      (clr),
      .live_bcd (live_bcd),
      .last_bcd (last_bcd),
      .last_ovf (last_ovf),
      .ovf      (ovf),
      .done     (done),
      .busy     (busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no report (t=%0t)", $time);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("report_last", {7'd0, last_bcd, last_ovf}, {7'd0, e});
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse();
      p_in = 1'b1;
      tick();
      p_in = 1'b0;
      tick();
   endtask

   task automatic open_window();
      l_in = 1'b1;
      tick();
   endtask

   // drops l_in and returns in the REPORT cycle
   task automatic close_window(input logic [7:0] exp_bcd, input logic exp_ovf);
      l_in = 1'b0;
      exp_q.push_back({exp_bcd, exp_ovf});
      tick();
   endtask

   initial begin
      // reset
      #1 reset = 1'b0;
      tick();
      check("rst_live", {8'd0, live_bcd}, 16'h0000);
      check("rst_last", {8'd0, last_bcd}, 16'h0000);
      check("rst_flags", {12'd0, ovf, last_ovf, done, busy}, 16'h0000);
      reset = 1'b1;
      tick();
      tick();

      // scenario 1: 5 isolated pulses in a 20-cycle window
      open_window();
      for (int i = 0; i < 20; i++) begin
         p_in = (i % 4 == 1);
         tick();
      end
      p_in = 1'b0;
      check("s1_live", {8'd0, live_bcd}, 16'h0005);
      check("s1_busy", {15'd0, busy}, 16'h0001);
      close_window(8'h05, 1'b0);
      check("s1_done", {15'd0, done}, 16'h0001);
      tick();
      check("s1_done_low", {15'd0, done}, 16'h0000);

      // scenario 2: digit carry
      open_window();
      for (int k = 1; k <= 12; k++) begin
         pulse();
         if (k == 9)  check("s2_live9", {8'd0, live_bcd}, 16'h0009);
         if (k == 10) check("s2_live10", {8'd0, live_bcd}, 16'h0010);
      end
      close_window(8'h12, 1'b0);
      tick();

      // scenario 3: saturation, then restart during REPORT
      open_window();
      for (int k = 1; k <= 105; k++) begin
         pulse();
         if (k == 99) begin
            check("s3_live99", {8'd0, live_bcd}, 16'h0099);
            check("s3_ovf_pre", {15'd0, ovf}, 16'h0000);
         end
         if (k == 100) check("s3_ovf_100", {15'd0, ovf}, 16'h0001);
      end
      check("s3_live_hold", {8'd0, live_bcd}, 16'h0099);
      close_window(8'h99, 1'b1);
      l_in = 1'b1;
      p_in = 1'b1;
      tick();
      check("s4c_live", {8'd0, live_bcd}, 16'h0001);
      check("s4c_ovf", {15'd0, ovf}, 16'h0000);
      check("s4c_last", {7'd0, last_bcd, last_ovf}, {7'd0, 8'h99, 1'b1});
      check("s4c_busy", {15'd0, busy}, 16'h0001);
      p_in = 1'b0;
      tick();
      close_window(8'h01, 1'b0);
      tick();

      // scenario 4a: one-cycle window with a coincident edge
      l_in = 1'b1;
      p_in = 1'b1;
      tick();
      p_in = 1'b0;
      close_window(8'h01, 1'b0);
      tick();
      check("s4a_idle", {14'd0, done, busy}, 16'h0000);

      // scenario 4b: edge coincident with window close is not counted
      open_window();
      pulse();
      pulse();
      p_in = 1'b1;
      close_window(8'h02, 1'b0);
      p_in = 1'b0;
      tick();
      check("s4b_live", {8'd0, live_bcd}, 16'h0002);

      // scenario 5a: clear mid-window
      open_window();
      pulse();
      pulse();
      pulse();
      check("s5_live3", {8'd0, live_bcd}, 16'h0003);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      l_in = 1'b0;
      check("s5_clr_live", {8'd0, live_bcd}, 16'h0000);
      check("s5_clr_last", {8'd0, last_bcd}, 16'h0000);
      check("s5_clr_flags", {12'd0, ovf, last_ovf, done, busy}, 16'h0000);
      tick();
      tick();

      // scenario 5b: asynchronous reset mid-window
      open_window();
      pulse();
      pulse();
      check("s5_live2", {8'd0, live_bcd}, 16'h0002);
      #2 reset = 1'b0;
      #1;
      check("s5_rst_live", {8'd0, live_bcd}, 16'h0000);
      check("s5_rst_flags", {12'd0, ovf, last_ovf, done, busy}, 16'h0000);
      l_in = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) tick();

      check("sb_drained", 16'(exp_q.size()), 16'h0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_burst_counter.md
PULSE_BURST_COUNTER -- requirements
Module: pulse_burst_counter

Interface
REQ-001 The block SHALL have these ports, one clock domain:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- p_in  input  1  pulse output P of pulse_generator; one counted event per rising edge.
- l_in  input  1  window output L of pulse_generator; a burst window is open while high.
- clr  input  1  synchronous clear, active-high.
- live_bcd  output  8  running count of the current window; [7:4] tens, [3:0] ones, BCD.
- last_bcd  output  8  count captured at the close of the most recent window, BCD.
- last_ovf  output  1  overflow flag captured with last_bcd.
- ovf  output  1  overflow flag of the current window, sticky until the window restarts.
- done  output  1  one-cycle strobe marking window close.
- busy  output  1  high while state is WINDOW.
REQ-002 Parameter SHALL be CNT_MAX, default 99, giving the saturation value; it SHALL be legal only from 1 to 99.

Function
REQ-003 p_rise SHALL be p_in AND NOT p_q, where p_q is p_in registered once; no synchronizer is included because both inputs are same-clock.
REQ-004 The FSM SHALL have three states: IDLE, WINDOW and REPORT.
REQ-005 In IDLE, when l_in=1, the FSM SHALL go to WINDOW, clear ovf, and load live to 1 if p_rise else 0; otherwise it SHALL stay in IDLE with live unchanged.
REQ-006 In WINDOW, when l_in=1, live SHALL increment by 1 in BCD on p_rise: ones wrap 9->0 with a carry into tens.
REQ-007 In WINDOW, on p_rise with live=CNT_MAX, live SHALL hold and ovf SHALL set to 1.
REQ-008 In WINDOW, when l_in=0, the FSM SHALL go to REPORT, set last_bcd to live and last_ovf to ovf, and SHALL NOT count p_rise in that cycle.
REQ-009 In REPORT, done SHALL be 1 (Moore output). done SHALL be 0 in every other state.
REQ-010 REPORT SHALL last exactly one cycle.
- If l_in=1, it SHALL go to WINDOW with the same live/ovf load as REQ-005.
- If l_in=0, it SHALL go to IDLE.
REQ-011 busy SHALL equal (state==WINDOW).
REQ-012 clr=1 SHALL override all other inputs: next state IDLE, and live, last_bcd, ovf, last_ovf and p_q all cleared; done SHALL be 0 in the following cycle.
REQ-013 A one-cycle l_in high pulse SHALL produce a single WINDOW cycle followed by REPORT, with last_bcd equal to 00 or 01.
REQ-014 Latency from the close of the window (l_in sampled 0) to done=1 SHALL be exactly one clock cycle.

Reset
REQ-015 On reset=0, the block SHALL go asynchronously to IDLE with p_q=0 and all outputs at 0: live_bcd=00, last_bcd=00, ovf=0, last_ovf=0, done=0, busy=0.
REQ-016 Reset asserted mid-window SHALL discard the count without producing a done strobe.
REQ-017 Reset deassertion SHALL take effect at the next rising clk edge.

Structure
REQ-018 Shared package pulse_pkg SHALL hold the FSM state encoding (IDLE=2'b00, WINDOW=2'b01, REPORT=2'b10) and the BCD digit width constant 4.
REQ-019 The two-digit BCD saturating counter SHALL be a sub-module named bcd_counter_2d.
- Inputs: clk, reset, load, load_val, inc.
- Outputs: value[7:0], at_max.
REQ-020 The encoding 2'b11 SHALL be unreachable; if it is entered, the FSM SHALL recover to IDLE on the next edge.

Verification
REQ-021 Scenario 1, basic count: hold l_in=1 for 20 cycles with 5 isolated p_in pulses, then l_in=0 -> live_bcd=0x05, done high for 1 cycle, last_bcd=0x05, last_ovf=0.
REQ-022 Scenario 2, digit carry: 12 pulses in one window -> live_bcd goes 0x09 then 0x10, and last_bcd=0x12.
REQ-023 Scenario 3, saturation: 105 pulses in one window -> live_bcd holds at 0x99, ovf=1 from the 100th pulse, last_ovf=1.
REQ-024 Scenario 4, simultaneous edges:
- p_in rises in the same cycle l_in rises -> count 01.
- p_in rises in the same cycle l_in falls -> not counted.
- New window starts during REPORT -> live restarts from 00 or 01 and last_bcd is preserved.
REQ-025 Scenario 5, clear and reset: clr=1 mid-window after 3 pulses -> all outputs 0 the next cycle and no done; reset=0 asynchronously mid-window -> outputs 0 immediately, no done after release.
